// File: rtl/uart_block_host.sv
// uart_block_host: host end of the 128-bit-over-UART link.
// Sends one block as 16 8N1 frames on tx (first byte [127:120]).
// Rebuilds one block from 16 frames on rx (first byte lands in [127:120]).
// Latency: a block takes exactly 160*CLKS_PER_BIT cycles to send after acceptance.
//   recv_valid follows the last stop-bit sample by one cycle.
// Backpressure: send_ready is high only while the transmitter is idle.
//   send_valid is ignored while it is busy. The receive side cannot be stalled.
// Ports: clk, reset (async, active-high)
//        send_valid/send_block/send_ready  block to transmit
//        tx / rx                           serial lines, idle high
//        recv_valid/recv_block             completed received block
//        recv_frame_err/recv_timeout       one-cycle error pulses
// Optional: define RX_TIMEOUT_EN to discard a partial receive block.
//   The discard happens after 32 bit-times with no start edge.
//   Without it, recv_timeout is tied low.
module uart_block_host #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int BYTES_PER_BLOCK = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         send_valid,
  input  logic [8*BYTES_PER_BLOCK-1:0] send_block,
  output logic                         send_ready,
  output logic                         tx,
  input  logic                         rx,
  output logic                         recv_valid,
  output logic [8*BYTES_PER_BLOCK-1:0] recv_block,
  output logic                         recv_frame_err,
  output logic                         recv_timeout
);

  localparam int BLK_W = 8 * BYTES_PER_BLOCK;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(BYTES_PER_BLOCK);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- TX
  state_t             tx_st, tx_st_n;
  logic [CNT_W-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]         tx_bit, tx_bit_n;
  logic [IDX_W-1:0]   tx_idx, tx_idx_n;
  logic [BLK_W-1:0]   tx_blk, tx_blk_n;
  logic [7:0]         tx_byte;
  logic               tx_q, tx_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_idx <= '0;
      tx_blk <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_idx <= tx_idx_n;
      tx_blk <= tx_blk_n;
      tx_q   <= tx_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_idx_n = tx_idx;
    tx_blk_n = tx_blk;
    tx_byte  = 8'h00;
    tx_n     = 1'b1;
    case (tx_st)
      S_IDLE: begin
        if (send_valid) begin
          tx_blk_n = send_block;
          tx_idx_n = '0;
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = S_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) tx_st_n = S_STOP;
          else                tx_bit_n = tx_bit + 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (tx_idx == LAST_IDX) begin
            tx_st_n = S_IDLE;
          end else begin
            // The block register shifts so the byte on the wire is always at the top.
            tx_idx_n = tx_idx + 1'b1;
            tx_blk_n = {tx_blk[BLK_W-9:0], 8'h00};
            tx_st_n  = S_START;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_st_n = S_IDLE;
    endcase
    // tx is registered from the next state so the line stays glitch-free.
    // It stays aligned with the state register.
    tx_byte = tx_blk_n[BLK_W-1 -: 8];
    case (tx_st_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = tx_byte[tx_bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  assign send_ready = (tx_st == S_IDLE);
  assign tx         = tx_q;

  // ---------------------------------------------------------------- RX
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  state_t             rx_st, rx_st_n;
  logic [CNT_W-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]         rx_bit, rx_bit_n;
  logic               shift_en, stop_smp;
  logic [7:0]         rx_shift;
  logic [BLK_W-1:0]   rx_asm;
  logic [IDX_W-1:0]   rx_idx;
  logic               gap_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    case (rx_st)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_fall) rx_st_n = S_START;
      end
      S_START: begin
        // Resample at mid start bit; a high line means the edge was a glitch.
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          shift_en = 1'b1;
          if (rx_bit == 3'd7) rx_st_n = S_STOP;
          else                rx_bit_n = rx_bit + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          stop_smp = 1'b1;
          rx_st_n  = S_IDLE;
        end
      end
      default: begin
        rx_cnt_n = '0;
        rx_st_n  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift       <= '0;
      rx_asm         <= '0;
      rx_idx         <= '0;
      recv_block     <= '0;
      recv_valid     <= 1'b0;
      recv_frame_err <= 1'b0;
    end else begin
      recv_valid     <= 1'b0;
      recv_frame_err <= 1'b0;
      if (shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (stop_smp) begin
        if (rx_sync) begin
          // Bytes shift in at the bottom, so the first byte ends at the top after 16.
          rx_asm <= {rx_asm[BLK_W-9:0], rx_shift};
          if (rx_idx == LAST_IDX) begin
            recv_block <= {rx_asm[BLK_W-9:0], rx_shift};
            recv_valid <= 1'b1;
            rx_idx     <= '0;
          end else begin
            rx_idx <= rx_idx + 1'b1;
          end
        end else begin
          recv_frame_err <= 1'b1;
          rx_idx         <= '0;
          rx_asm         <= '0;
        end
      end else if (gap_hit) begin
        rx_idx <= '0;
        rx_asm <= '0;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(32 * CLKS_PER_BIT);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(32 * CLKS_PER_BIT - 1);
  logic [GAP_W-1:0] rx_gap;

  // The counter only runs while a partial block is waiting between frames.
  assign gap_hit = (rx_st == S_IDLE) && (rx_idx != '0) && !rx_fall && (rx_gap == GAP_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_gap       <= '0;
      recv_timeout <= 1'b0;
    end else begin
      recv_timeout <= gap_hit;
      if ((rx_st != S_IDLE) || (rx_idx == '0) || rx_fall || gap_hit) rx_gap <= '0;
      else                                                            rx_gap <= rx_gap + 1'b1;
    end
  end
`else
  assign gap_hit      = 1'b0;
  assign recv_timeout = 1'b0;
`endif

endmodule
